fetch_queue: RTL and testbench

Parametrised instruction-fetch front end that sits between the instruction memory port and the IF/ID pipeline register of the pipelined core. It replaces the single PC register and `~stall_if && ~mem_busy` gating with a fetch state machine and a DEPTH-entry instruction queue. Fetching proceeds while decode is stalled. Redirects (branch, jump, trap, xRET) flush the queue in one cycle and safely discard an in-flight memory transaction.

---
 rtl/fetch_queue_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_queue.sv | 140 ++++++++++++++
 tb/tb_fetch_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction-fetch front end: FSM states and queue entry layout.
package fetch_queue_pkg;

  localparam int unsigned MaxXlen   = 64;
  localparam int unsigned InstWidth = 32;

  typedef logic [InstWidth-1:0] instruction_t;

  typedef enum logic [1:0] {
    Fetch = 2'd0,
    Full  = 2'd1,
    Drop  = 2'd2
  } fetch_state_t;

  // pc is stored at RV64 width; narrower cores truncate on use.
  typedef struct packed {
    logic [MaxXlen-1:0] pc;
    instruction_t       inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO with combinational head read; flush beats push and pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd];
  assign count  = r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; head is only consumed when count is non-zero.
  always_ff @(posedge clock) begin
    if (w_push && !flush) r_mem[r_wr] <= data_in;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: fetch FSM feeding a DEPTH-entry queue toward ID, with redirect flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned          DATA_SIZE = 32,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [DATA_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     fetch_req,
  output logic [DATA_SIZE-1:0]     fetch_addr,
  input  logic                     mem_busy,
  input  logic [31:0]              inst,
  input  logic                     redirect,
  input  logic [DATA_SIZE-1:0]     redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [DATA_SIZE-1:0]     out_pc,
  output logic [DATA_SIZE-1:0]     out_pc_plus_4,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  fetch_state_t         r_state;
  logic [DATA_SIZE-1:0] r_pc;
  logic                 r_req;
  logic [DATA_SIZE-1:0] r_addr;

  logic                 w_done;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fill;
  logic                 w_full;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic [DATA_SIZE-1:0] w_pc_next;
  logic [DATA_SIZE-1:0] w_redir_pc;
  logic [EW-1:0]        w_head_bits;
  fetch_entry_t         w_entry;
  fetch_entry_t         w_head;
  logic                 w_unused;

  assign w_done     = r_req && !mem_busy;
  assign w_pop      = !w_empty && out_ready;
  assign w_push     = (r_state == Fetch) && w_done && !redirect && !w_full;
  assign w_fill     = (w_count == CW'(DEPTH - 1)) && !w_pop;
  assign w_pc_next  = r_pc + DATA_SIZE'(4);
  assign w_redir_pc = {redirect_pc[DATA_SIZE-1:2], 2'b00};

  assign w_entry.pc   = MaxXlen'(r_pc);
  assign w_entry.inst = inst;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (redirect),
    .data_in (w_entry),
    .head    (w_head_bits),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_head        = fetch_entry_t'(w_head_bits);
  assign out_valid     = !w_empty;
  assign out_inst      = w_empty ? 32'h0 : w_head.inst;
  assign out_pc        = w_empty ? '0 : w_head.pc[DATA_SIZE-1:0];
  assign out_pc_plus_4 = out_pc + DATA_SIZE'(4);
  assign queue_count   = w_count;
  assign fetch_req     = r_req;
  assign fetch_addr    = r_addr;
  // Upper pc bits are unused on RV32 builds.
  assign w_unused      = ^w_head.pc;

  // Fetch FSM; fetch_req/fetch_addr are registered from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= Fetch;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
    end else if (redirect) begin
      r_pc <= w_redir_pc;
      if ((r_state == Fetch || r_state == Drop) && r_req && mem_busy) begin
        // Transaction in flight: keep request and address until it completes.
        r_state <= Drop;
        r_req   <= 1'b1;
      end else begin
        r_state <= Fetch;
        r_req   <= 1'b1;
        r_addr  <= w_redir_pc;
      end
    end else begin
      unique case (r_state)
        Fetch: begin
          if (w_done) begin
            r_pc   <= w_pc_next;
            r_addr <= w_pc_next;
            if (w_fill) begin
              r_state <= Full;
              r_req   <= 1'b0;
            end else begin
              r_req <= 1'b1;
            end
          end else begin
            r_req <= 1'b1;
          end
        end
        Full: begin
          if (w_pop) begin
            r_state <= Fetch;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        Drop: begin
          if (w_done) begin
            r_state <= Fetch;
            r_addr  <= r_pc;
          end
        end
        default: begin
          r_state <= Fetch;
          r_req   <= 1'b1;
          r_addr  <= r_pc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, stream, redirects (idle, busy, completing, in FULL), reset in DROP.
module tb_fetch_queue;

  logic        clock;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        mem_busy;
  logic [31:0] inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [2:0]  queue_count;

  int n_vec = 0;
  int n_err = 0;

  fetch_queue #(
    .DATA_SIZE (32),
    .DEPTH     (4),
    .RESET_PC  (32'h0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .mem_busy      (mem_busy),
    .inst          (inst),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_pc_plus_4 (out_pc_plus_4),
    .queue_count   (queue_count)
  );

  // Memory model: instruction word is a tag xor its address.
  assign inst = fetch_addr ^ 32'hC0DE0000;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Stability of a stalled request and occupancy bound, sampled mid-cycle.
  logic        m_prev_stall = 1'b0;
  logic [31:0] m_prev_addr  = '0;
  always @(negedge clock) begin
    if (reset) begin
      m_prev_stall = 1'b0;
    end else begin
      if (m_prev_stall) begin
        check("hold_req", 64'(fetch_req), 64'h1);
        check("hold_addr", 64'(fetch_addr), 64'(m_prev_addr));
      end
      check("count_le_depth", 64'(queue_count <= 3'd4), 64'h1);
      m_prev_stall = fetch_req && mem_busy;
      m_prev_addr  = fetch_addr;
    end
  end

  initial begin
    reset       = 1'b1;
    mem_busy    = 1'b0;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
    check("rst_req", 64'(fetch_req), 64'h0);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_count", 64'(queue_count), 64'h0);
    check("rst_inst", 64'(out_inst), 64'h0);
    check("rst_pc", 64'(out_pc), 64'h0);

    // Fill: four completions, then FULL.
    reset = 1'b0;
    tick();
    check("fill_req0", 64'(fetch_req), 64'h1);
    check("fill_addr0", 64'(fetch_addr), 64'h0);
    tick();
    check("fill_lat_valid", 64'(out_valid), 64'h1);
    check("fill_lat_pc", 64'(out_pc), 64'h0);
    check("fill_addr1", 64'(fetch_addr), 64'h4);
    tick();
    tick();
    tick();
    check("fill_req_off", 64'(fetch_req), 64'h0);
    check("fill_count", 64'(queue_count), 64'h4);
    check("fill_pc", 64'(out_pc), 64'h0);
    check("fill_pc4", 64'(out_pc_plus_4), 64'h4);
    check("fill_inst", 64'(out_inst), 64'hC0DE0000);
    tick();
    check("full_hold_req", 64'(fetch_req), 64'h0);
    check("full_hold_count", 64'(queue_count), 64'h4);

    // Pop out of FULL, then pop + completion together keeps count.
    out_ready = 1'b1;
    tick();
    check("unfull_count", 64'(queue_count), 64'h3);
    check("unfull_req", 64'(fetch_req), 64'h1);
    check("unfull_addr", 64'(fetch_addr), 64'h10);
    check("unfull_pc", 64'(out_pc), 64'h4);
    tick();
    check("pushpop_count", 64'(queue_count), 64'h3);
    check("pushpop_req", 64'(fetch_req), 64'h1);
    check("pushpop_addr", 64'(fetch_addr), 64'h14);
    check("pushpop_pc", 64'(out_pc), 64'h8);
    out_ready = 1'b0;
    tick();
    check("refull_req", 64'(fetch_req), 64'h0);
    check("refull_count", 64'(queue_count), 64'h4);

    // Redirect in FULL.
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    check("rdfull_count", 64'(queue_count), 64'h0);
    check("rdfull_valid", 64'(out_valid), 64'h0);
    check("rdfull_req", 64'(fetch_req), 64'h1);
    check("rdfull_addr", 64'(fetch_addr), 64'h300);
    tick();
    check("rdfull_out_valid", 64'(out_valid), 64'h1);
    check("rdfull_out_pc", 64'(out_pc), 64'h300);

    // Stream one instruction per cycle.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stream_pc", 64'(out_pc), 64'(32'h304 + 32'(4 * k)));
      check("stream_pc4", 64'(out_pc_plus_4), 64'(32'h308 + 32'(4 * k)));
      check("stream_count", 64'(queue_count), 64'h1);
    end

    // Redirect coinciding with completion at 0x314; low pc bits forced to zero.
    out_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    mem_busy = 1'b1;
    check("rdcmp_addr", 64'(fetch_addr), 64'h200);
    check("rdcmp_req", 64'(fetch_req), 64'h1);
    check("rdcmp_valid", 64'(out_valid), 64'h0);
    check("rdcmp_count", 64'(queue_count), 64'h0);
    tick();
    check("busy_addr", 64'(fetch_addr), 64'h200);

    // Redirect while busy: DROP holds 0x200 until completion.
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("drop_req", 64'(fetch_req), 64'h1);
    check("drop_addr", 64'(fetch_addr), 64'h200);
    check("drop_valid", 64'(out_valid), 64'h0);
    tick();
    check("drop_addr2", 64'(fetch_addr), 64'h200);
    mem_busy = 1'b0;
    tick();
    check("postdrop_addr", 64'(fetch_addr), 64'h100);
    check("postdrop_valid", 64'(out_valid), 64'h0);
    check("postdrop_count", 64'(queue_count), 64'h0);
    tick();
    check("postdrop_out_valid", 64'(out_valid), 64'h1);
    check("postdrop_out_pc", 64'(out_pc), 64'h100);
    check("postdrop_out_inst", 64'(out_inst), 64'hC0DE0100);

    // Reset asserted while in DROP.
    mem_busy    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'h0);
    reset = 1'b1;
    #1;
    check("rstdrop_req", 64'(fetch_req), 64'h0);
    check("rstdrop_valid", 64'(out_valid), 64'h0);
    tick();
    check("rstdrop_req2", 64'(fetch_req), 64'h0);
    check("rstdrop_count", 64'(queue_count), 64'h0);
    reset    = 1'b0;
    mem_busy = 1'b0;
    tick();
    check("rel_req", 64'(fetch_req), 64'h1);
    check("rel_addr", 64'(fetch_addr), 64'h0);
    tick();
    check("rel_out_valid", 64'(out_valid), 64'h1);
    check("rel_out_pc", 64'(out_pc), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
